// File: rtl/alu_arbiter_if.sv
// Requester-side operation and response channels of the shared-ALU arbiter.
// The arbiter uses the slave modport; issue logic uses the master modport.
interface alu_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 64
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [4*NREQ-1:0]     req_ctl;
   logic [WIDTH*NREQ-1:0] req_a;
   logic [WIDTH*NREQ-1:0] req_b;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]      rsp_result;
   logic                  rsp_zero;
   logic                  rsp_err;

   modport master (
      output req_valid, req_ctl, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
   );

   modport slave (
      input  req_valid, req_ctl, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between NREQ requesters;
// rejects illegal opcodes and divide-by-zero without using the ALU.
module alu_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 64,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_arbiter_if.slave     bus,
   output logic [3:0]       alu_ctl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic             busy,
   output logic [IDW-1:0]   grant_id
);

   typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

   state_t           state;
   state_t           state_nx;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   idx;
   logic [IDW-1:0]   win;
   logic             found;
   logic [3:0]       win_ctl;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;
   logic             win_bad;
   logic             accept;
   logic             done;
   logic             reject;
   logic [NREQ-1:0]  ready_c;
   logic [NREQ-1:0]  valid_c;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             err_q;

   // First valid requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = ptr;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
         idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
      end
   end

   always_comb begin
      win_ctl = '0;
      win_a   = '0;
      win_b   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win == IDW'(i)) begin
            win_ctl = bus.req_ctl[4*i +: 4];
            win_a   = bus.req_a[WIDTH*i +: WIDTH];
            win_b   = bus.req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   assign win_bad = (win_ctl == 4'd0) || (win_ctl > 4'd7) ||
                    ((win_ctl == 4'd6) && (win_b == '0));

   always_comb begin
      state_nx = state;
      ready_c  = '0;
      valid_c  = '0;
      accept   = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               ready_c[win] = 1'b1;
               accept       = 1'b1;
               // Rejected ops skip EXEC; CAPT then holds the preloaded error response.
               state_nx     = win_bad ? CAPT : EXEC;
            end
         end
         EXEC: state_nx = CAPT;
         CAPT: state_nx = RESP;
         RESP: begin
            valid_c[grant_id] = 1'b1;
            if (bus.rsp_ready[grant_id]) begin
               done     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         grant_id <= '0;
         alu_ctl  <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         reject   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            grant_id <= win;
            alu_ctl  <= win_ctl;
            alu_a    <= win_a;
            alu_b    <= win_b;
            reject   <= win_bad;
            if (win_bad) begin
               result_q <= '0;
               zero_q   <= 1'b1;
               err_q    <= 1'b1;
            end
         end
         if ((state == CAPT) && !reject) begin
            result_q <= alu_out;
            zero_q   <= alu_zero;
            err_q    <= 1'b0;
         end
         if (done) begin
            ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
         end
      end
   end

   assign busy           = (state != IDLE);
   assign bus.req_ready  = ready_c;
   assign bus.rsp_valid  = valid_c;
   assign bus.rsp_result = result_q;
   assign bus.rsp_zero   = zero_q;
   assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: registered ALU stand-in, transaction-level reference
// model compared every cycle, directed scenarios plus randomized traffic.
module tb_alu_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 64;
   localparam int IDW   = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   logic [3:0]       alu_ctl;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_out;
   logic             alu_zero;
   logic             busy;
   logic [IDW-1:0]   grant_id;

   alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .alu_ctl  (alu_ctl),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_out  (alu_out),
      .alu_zero (alu_zero),
      .busy     (busy),
      .grant_id (grant_id)
   );

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [63:0] alu_f(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
      case (c)
         4'd1: return a + b;
         4'd2: return a - b;
         4'd3: return a * b;
         4'd4: return a << b[5:0];
         4'd5: return a & b;
         4'd6: return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
         4'd7: return a | b;
         default: return 64'h0000_0000_DEAD_BEEF;
      endcase
   endfunction

   // ALU stand-in: one-cycle registered result.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out  <= '0;
         alu_zero <= 1'b0;
      end else begin
         alu_out  <= alu_f(alu_ctl, alu_a, alu_b);
         alu_zero <= (alu_f(alu_ctl, alu_a, alu_b) == 64'd0);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [NREQ-1:0] onehot(input int x);
      logic [NREQ-1:0] v;
      v = '0;
      v[IDW'(x)] = 1'b1;
      return v;
   endfunction

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[IDW'((p + k) % NREQ)]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   // Reference model: owner of the single outstanding op, cycles left until
   // its response is visible, and the response it must carry.
   int          m_owner = -1;
   int          m_wait  = 0;
   int          m_ptr   = 0;
   int          m_gid   = 0;
   logic [3:0]  m_ctl   = '0;
   logic [63:0] m_a     = '0;
   logic [63:0] m_b     = '0;
   logic [63:0] m_res   = '0;
   logic        m_zero  = 1'b0;
   logic        m_err   = 1'b0;

   initial begin : compare
      int              w;
      logic [NREQ-1:0] exp_ready;
      logic [NREQ-1:0] exp_valid;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            m_owner = -1; m_wait = 0; m_ptr = 0; m_gid = 0;
            m_ctl = '0; m_a = '0; m_b = '0;
            #1;
            if (!rst_n) begin
               chk("rst_busy", 64'(busy), 64'd0);
               chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
               chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
               chk("rst_grant_id", 64'(grant_id), 64'd0);
               chk("rst_alu_ctl", 64'(alu_ctl), 64'd0);
               chk("rst_alu_a", alu_a, 64'd0);
               chk("rst_alu_b", alu_b, 64'd0);
               chk("rst_rsp_result", bus.rsp_result, 64'd0);
               chk("rst_rsp_zero", 64'(bus.rsp_zero), 64'd0);
               chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
            end
         end else begin
            w = rr_pick(bus.req_valid, m_ptr);
            exp_ready = (m_owner < 0 && w >= 0) ? onehot(w) : '0;
            exp_valid = (m_owner >= 0 && m_wait == 0) ? onehot(m_owner) : '0;
            chk("busy", 64'(busy), 64'(m_owner >= 0));
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
            chk("grant_id", 64'(grant_id), 64'(m_gid));
            chk("alu_ctl", 64'(alu_ctl), 64'(m_ctl));
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            if (exp_valid != '0) begin
               chk("rsp_result", bus.rsp_result, m_res);
               chk("rsp_zero", 64'(bus.rsp_zero), 64'(m_zero));
               chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
            end
            if (m_owner < 0) begin
               if (w >= 0) begin
                  m_owner = w;
                  m_gid   = w;
                  m_ctl   = 4'(bus.req_ctl >> (4 * w));
                  m_a     = 64'(bus.req_a >> (WIDTH * w));
                  m_b     = 64'(bus.req_b >> (WIDTH * w));
                  if (m_ctl >= 4'd1 && m_ctl <= 4'd7 && !(m_ctl == 4'd6 && m_b == 64'd0)) begin
                     m_res = alu_f(m_ctl, m_a, m_b); m_zero = (m_res == 64'd0); m_err = 1'b0; m_wait = 2;
                  end else begin
                     m_res = 64'd0; m_zero = 1'b1; m_err = 1'b1; m_wait = 1;
                  end
               end
            end else if (m_wait > 0) begin
               m_wait--;
            end else if (bus.rsp_ready[IDW'(m_owner)]) begin
               m_ptr   = (m_owner + 1) % NREQ;
               m_owner = -1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_valid = '0;
      bus.req_ctl   = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = '0;
   endtask

   task automatic set_req(input int i, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
      bus.req_valid[IDW'(i)]    = 1'b1;
      bus.req_ctl[4*i +: 4]     = c;
      bus.req_a[WIDTH*i +: WIDTH] = a;
      bus.req_b[WIDTH*i +: WIDTH] = b;
   endtask

   // Returns one time unit after the accepting edge.
   task automatic wait_grant(output int w, output int cyc);
      w = -1;
      cyc = 0;
      while (w < 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         for (int j = 0; j < NREQ; j++) if (bus.req_ready[IDW'(j)]) w = j;
      end
      if (w < 0) begin
         n_vec++; n_err++;
         $display("FAIL grant_timeout: no req_ready within 40 cycles (t=%0t)", $time);
      end
      tick();
   endtask

   task automatic wait_rsp(input int i, output int lat);
      lat = -1;
      for (int k = 0; k <= 20; k++) begin
         if (bus.rsp_valid[IDW'(i)]) begin
            lat = k;
            break;
         end
         tick();
      end
      if (lat < 0) begin
         n_vec++; n_err++;
         $display("FAIL rsp_timeout: requester %0d got no rsp_valid (t=%0t)", i, $time);
      end
   endtask

   task automatic finish_rsp(input int i);
      bus.rsp_ready[IDW'(i)] = 1'b1;
      tick();
      bus.rsp_ready[IDW'(i)] = 1'b0;
   endtask

   task automatic check_rsp(input string name, input logic [63:0] res, input logic zero, input logic err);
      chk({name, "_result"}, bus.rsp_result, res);
      chk({name, "_zero"}, 64'(bus.rsp_zero), 64'(zero));
      chk({name, "_err"}, 64'(bus.rsp_err), 64'(err));
   endtask

   task automatic do_op(input string name, input int i, input logic [3:0] c, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] res, input logic zero, input logic err,
                        input int lat_exp);
      int w, cyc, lat;
      set_req(i, c, a, b);
      wait_grant(w, cyc);
      bus.req_valid[IDW'(i)] = 1'b0;
      chk({name, "_grant"}, 64'(w), 64'(i));
      wait_rsp(i, lat);
      chk({name, "_latency"}, 64'(lat), 64'(lat_exp));
      check_rsp(name, res, zero, err);
      finish_rsp(i);
   endtask

   initial begin : stim
      int w, cyc, lat;
      clear_inputs();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      do_op("add", 0, 4'd1, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 2);

      // Async reset pulse between edges to restart the pointer at 0.
      rst_n = 1'b0; #2; rst_n = 1'b1;
      tick();
      for (int i = 0; i < NREQ; i++) set_req(i, 4'd2, 64'd10, 64'(i));
      for (int n = 0; n < NREQ; n++) begin
         wait_grant(w, cyc);
         chk("rr_order", 64'(w), 64'(n));
         if (w >= 0) begin
            bus.req_valid[IDW'(w)] = 1'b0;
            wait_rsp(w, lat);
            check_rsp("rr", 64'(10 - n), 1'b0, 1'b0);
            finish_rsp(w);
         end
      end
      set_req(1, 4'd2, 64'd10, 64'd1);
      wait_grant(w, cyc);
      bus.req_valid[1] = 1'b0;
      chk("lone_grant", 64'(w), 64'd1);
      chk("lone_grant_cycles", 64'(cyc), 64'd1);
      wait_rsp(1, lat);
      check_rsp("lone", 64'd9, 1'b0, 1'b0);
      finish_rsp(1);

      do_op("div0", 2, 4'd6, 64'd9, 64'd0, 64'd0, 1'b1, 1'b1, 1);
      do_op("ctl0", 3, 4'd0, 64'd4, 64'd4, 64'd0, 1'b1, 1'b1, 1);
      do_op("ctl9", 0, 4'd9, 64'd4, 64'd4, 64'd0, 1'b1, 1'b1, 1);

      // Response held back while other requesters wait.
      set_req(2, 4'd2, 64'd3, 64'd3);
      wait_grant(w, cyc);
      bus.req_valid[2] = 1'b0;
      chk("hold_grant", 64'(w), 64'd2);
      wait_rsp(2, lat);
      set_req(0, 4'd1, 64'd1, 64'd1);
      set_req(3, 4'd1, 64'd1, 64'd1);
      for (int k = 0; k < 5; k++) begin
         chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'b0100);
         chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
         check_rsp("hold", 64'd0, 1'b1, 1'b0);
         tick();
      end
      bus.req_valid = '0;
      finish_rsp(2);

      do_op("mul_trunc", 1, 4'd3, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1, 1'b0, 2);
      do_op("shl", 1, 4'd4, 64'd1, 64'd4, 64'd16, 1'b0, 1'b0, 2);
      do_op("pre_rst", 2, 4'd1, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 2);

      // Reset while an op is in EXEC: dropped, pointer back to 0.
      set_req(3, 4'd1, 64'd2, 64'd2);
      wait_grant(w, cyc);
      bus.req_valid[3] = 1'b0;
      chk("exec_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_busy", 64'(busy), 64'd0);
      chk("async_alu_ctl", 64'(alu_ctl), 64'd0);
      chk("async_grant_id", 64'(grant_id), 64'd0);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      end
      set_req(1, 4'd7, 64'hF0, 64'h0F);
      set_req(3, 4'd1, 64'd2, 64'd2);
      wait_grant(w, cyc);
      bus.req_valid = '0;
      chk("post_rst_grant", 64'(w), 64'd1);
      wait_rsp(1, lat);
      check_rsp("post_rst", 64'hFF, 1'b0, 1'b0);
      finish_rsp(1);

      // Randomized traffic; the compare process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         bus.req_valid = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
         bus.rsp_ready = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            int unsigned r;
            logic [63:0] a, b;
            r = $urandom_range(0, 15);
            a = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
            case ($urandom_range(0, 7))
               0, 1:    b = 64'd0;
               2:       b = a;
               3:       b = 64'($urandom_range(0, 70));
               default: b = {$urandom, $urandom};
            endcase
            bus.req_ctl[4*i +: 4]       = (r < 11) ? 4'(1 + r % 7) : 4'($urandom_range(0, 15));
            bus.req_a[WIDTH*i +: WIDTH] = a;
            bus.req_b[WIDTH*i +: WIDTH] = b;
         end
         tick();
      end
      clear_inputs();
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
